pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Run/step/halt sequencer and load-use hazard controller for the 5-stage MIPS pipeline. Drives the freeze input (`i_halt`) of every pipeline register and the PC, and the stall/bubble controls of PC, IF/ID and ID/EX. Implements the debug execution modes: continuous, single-step, and drain-on-HALT. Sits beside the ID stage and is commanded by the debug unit.

## Interface
- `NB_CYCLES`, 32: width of the executed-cycle counter.
- `DRAIN_CYCLES`, 4: free-running cycles after HALT decode needed to retire the instructions ahead of it.
- `clk` in 1: single clock; all state updates on its rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_mode_step` in 1: sampled with `i_start`; 1 = single-step mode, 0 = continuous mode.
- `i_start` in 1: one-cycle pulse that begins execution.
- `i_step` in 1: one-cycle pulse that advances one cycle in step mode.
- `i_clear` in 1: one-cycle pulse; returns the controller to IDLE and clears the counters.
- `i_halt_instr` in 1: instruction currently in ID is HALT.
- `i_idex_memRead` in 1: instruction in ID/EX is a load.
- `i_idex_rt` in 5: load destination register.
- `i_ifid_rs` in 5: source register rs of the instruction in IF/ID.
- `i_ifid_rt` in 5: source register rt of the instruction in IF/ID.
- `i_ifid_uses_rt` in 1: instruction in IF/ID reads rt.
- `o_halt` out 1: freezes all pipeline registers and the PC.
- `o_stall_pc_ifid` out 1: holds PC and IF/ID.
- `o_bubble_idex` out 1: loads a NOP into ID/EX (all control signals 0).
- `o_done` out 1: program finished and pipeline drained.
- `o_state` out 3: current FSM state encoding.
- `o_cycle_count` out NB_CYCLES: number of cycles executed.

## Operation
- **States:** IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, DONE.
- **IDLE:** `o_halt`=1.
  - `i_start` with `i_mode_step`=0 -> RUN.
  - `i_start` with `i_mode_step`=1 -> STEP_WAIT.
  - `i_step` in the same cycle as `i_start` is ignored.
- **RUN:** `o_halt`=0. `i_halt_instr` with no hazard -> DRAIN.
- **STEP_WAIT:** `o_halt`=1. `i_step` -> STEP_EXEC.
- **STEP_EXEC:** `o_halt`=0 for exactly one cycle.
  - `i_halt_instr` with no hazard -> DRAIN.
  - Otherwise -> STEP_WAIT.
- **DRAIN:**
  - `o_halt`=0 and `o_stall_pc_ifid`=1, so HALT is held in ID and nothing new is fetched.
  - `o_bubble_idex`=1 on every DRAIN cycle.
  - Drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; at 0 -> DONE.
  - DRAIN runs freely in both modes.
- **DONE:** `o_halt`=1, `o_done`=1. Stays in DONE until `i_clear` or reset.
- **Command priority:**
  - `i_clear` overrides every other input in every state: next state IDLE, both counters to 0.
  - `i_start` outside IDLE is ignored.
  - `i_step` outside STEP_WAIT is ignored.
- **Load-use hazard:**
  - hazard = `i_idex_memRead` & (`i_idex_rt`≠0) & ((`i_idex_rt`==`i_ifid_rs`) | (`i_ifid_uses_rt` & `i_idex_rt`==`i_ifid_rt`)).
  - Acted on only in RUN or STEP_EXEC; it then asserts `o_stall_pc_ifid`=1 and `o_bubble_idex`=1.
  - Hazard has priority over `i_halt_instr` in the same cycle. The HALT stays in ID and is taken on the next unfrozen cycle.
- **Cycle counter:** increments on every cycle with `o_halt`=0, including DRAIN. It saturates at 2^NB_CYCLES-1.

## Timing
- **Reset values:** state IDLE, `o_halt`=1, `o_done`=0, `o_stall_pc_ifid`=0, `o_bubble_idex`=0, `o_cycle_count`=0, `o_state`=IDLE encoding.
- `o_halt`, `o_done` and `o_state` are Moore outputs, decoded from the registered state.
- `o_stall_pc_ifid` and `o_bubble_idex` are combinational, valid in the same cycle as the hazard inputs.
- **Continuous-mode latency:** `i_start` at edge N gives `o_halt`=0 from cycle N+1.
- **HALT decode:** `i_halt_instr` seen in cycle K (RUN, no hazard) gives DRAIN over cycles K+1..K+DRAIN_CYCLES and DONE at K+DRAIN_CYCLES+1.
- **Step mode:** each `i_step` pulse yields exactly one unfrozen cycle, one cycle after the pulse.
- A reset asserted mid-run forces IDLE immediately, without waiting for a clock edge.

## Configuration
- `PIPE_CTRL_STALL_CNT_EN` defined:
  - Adds output `o_stall_count` [NB_CYCLES-1:0].
  - It counts cycles in which a hazard stall is acted on, saturating.
  - Cleared by reset and `i_clear`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- **Package `pipe_ctrl_pkg`:** state encodings (3-bit localparams) and the default DRAIN_CYCLES.
- **Sub-module `hazard_detect`:** the combinational load-use compare. It outputs the raw hazard flag, and `pipeline_ctrl` gates it by state.

## Test plan
- **Continuous run:** `i_start`, `i_mode_step`=0; `i_halt_instr` at cycle 10 -> DRAIN cycles 11–14, `o_done`=1 at 15, `o_cycle_count`=14.
- **Step mode:** three `i_step` pulses spaced 5 cycles apart -> exactly three single cycles with `o_halt`=0, `o_cycle_count`=3.
- **Load-use:** `i_idex_memRead`=1, `i_idex_rt`=5, `i_ifid_rs`=5 -> `o_stall_pc_ifid`=`o_bubble_idex`=1 that cycle. Repeat with `i_idex_rt`=0 -> no stall.
- **Hazard and HALT together:** hazard with `i_halt_instr` in the same cycle -> stays RUN; DRAIN starts one cycle after the hazard clears.
- **Clear priority:** `i_clear` together with `i_step` in STEP_WAIT -> IDLE, counters 0.
- **Reset mid-run:** `i_reset` low mid-DRAIN -> IDLE immediately, `o_halt`=1, `o_done`=0, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encodings and defaults for the pipeline run/step/halt controller
package pipe_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RUN       = 3'd1;
  localparam logic [2:0] ST_STEP_WAIT = 3'd2;
  localparam logic [2:0] ST_STEP_EXEC = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Cycles needed after HALT decode to retire the instructions ahead of it.
  localparam int DRAIN_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_RUN       = ST_RUN,
    S_STEP_WAIT = ST_STEP_WAIT,
    S_STEP_EXEC = ST_STEP_EXEC,
    S_DRAIN     = ST_DRAIN,
    S_DONE      = ST_DONE
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - raw load-use hazard compare between ID/EX and IF/ID
module hazard_detect (
  input  logic       i_idex_memRead,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_ifid_uses_rt,
  output logic       o_hazard
);

  // A load into $zero never creates a dependency; rt only matters when the consumer reads it.
  always_comb begin
    o_hazard = i_idex_memRead && (i_idex_rt != 5'd0) &&
               ((i_idex_rt == i_ifid_rs) || (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - run/step/drain sequencer and load-use stall control; optional PIPE_CTRL_STALL_CNT_EN adds o_stall_count
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NB_CYCLES    = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_mode_step,
  input  logic                 i_start,
  input  logic                 i_step,
  input  logic                 i_clear,
  input  logic                 i_halt_instr,
  input  logic                 i_idex_memRead,
  input  logic [4:0]           i_idex_rt,
  input  logic [4:0]           i_ifid_rs,
  input  logic [4:0]           i_ifid_rt,
  input  logic                 i_ifid_uses_rt,
  output logic                 o_halt,
  output logic                 o_stall_pc_ifid,
  output logic                 o_bubble_idex,
  output logic                 o_done,
  output logic [2:0]           o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [NB_CYCLES-1:0] o_stall_count
`endif
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0]       DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
  localparam logic [DCW-1:0]       DRAIN_ONE  = 1;
  localparam logic [NB_CYCLES-1:0] CYC_ONE    = 1;

  state_e                 state_q, state_d;
  logic [DCW-1:0]         drain_q, drain_d;
  logic [NB_CYCLES-1:0]   cycle_q, cycle_d;
  logic                   hazard_raw;
  logic                   executing;
  logic                   unfrozen;
  logic                   hazard_act;

  hazard_detect u_hazard_detect (
    .i_idex_memRead (i_idex_memRead),
    .i_idex_rt      (i_idex_rt),
    .i_ifid_rs      (i_ifid_rs),
    .i_ifid_rt      (i_ifid_rt),
    .i_ifid_uses_rt (i_ifid_uses_rt),
    .o_hazard       (hazard_raw)
  );

  // Pipeline runs in RUN/STEP_EXEC/DRAIN; a hazard only matters while new instructions are issuing.
  always_comb begin
    executing       = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
    unfrozen        = executing || (state_q == S_DRAIN);
    hazard_act      = executing && hazard_raw;
    o_halt          = !unfrozen;
    o_done          = (state_q == S_DONE);
    o_state         = state_q;
    o_stall_pc_ifid = hazard_act || (state_q == S_DRAIN);
    o_bubble_idex   = hazard_act || (state_q == S_DRAIN);
    o_cycle_count   = cycle_q;
  end

  // Next-state, drain countdown and saturating cycle count; clear overrides everything.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cycle_d = cycle_q;
    if (unfrozen && (cycle_q != '1)) cycle_d = cycle_q + CYC_ONE;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = i_mode_step ? S_STEP_WAIT : S_RUN;
      end
      S_RUN: begin
        if (i_halt_instr && !hazard_raw) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_STEP_WAIT: begin
        if (i_step) state_d = S_STEP_EXEC;
      end
      S_STEP_EXEC: begin
        if (i_halt_instr && !hazard_raw) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRAIN_ONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (i_clear) begin
      state_d = S_IDLE;
      drain_d = '0;
      cycle_d = '0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [NB_CYCLES-1:0] stall_q, stall_d;

  // Counts cycles in which a load-use stall was actually applied, saturating.
  always_comb begin
    stall_d = stall_q;
    if (hazard_act && (stall_q != '1)) stall_d = stall_q + CYC_ONE;
    if (i_clear) stall_d = '0;
    o_stall_count = stall_q;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) stall_q <= '0;
    else          stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset, i_mode_step, i_start, i_step, i_clear, i_halt_instr;
  logic        i_idex_memRead, i_ifid_uses_rt;
  logic [4:0]  i_idex_rt, i_ifid_rs, i_ifid_rt;
  logic        o_halt, o_stall_pc_ifid, o_bubble_idex, o_done;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] o_stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NB_CYCLES(32), .DRAIN_CYCLES(4)) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_mode_step     (i_mode_step),
    .i_start         (i_start),
    .i_step          (i_step),
    .i_clear         (i_clear),
    .i_halt_instr    (i_halt_instr),
    .i_idex_memRead  (i_idex_memRead),
    .i_idex_rt       (i_idex_rt),
    .i_ifid_rs       (i_ifid_rs),
    .i_ifid_rt       (i_ifid_rt),
    .i_ifid_uses_rt  (i_ifid_uses_rt),
    .o_halt          (o_halt),
    .o_stall_pc_ifid (o_stall_pc_ifid),
    .o_bubble_idex   (o_bubble_idex),
    .o_done          (o_done),
    .o_state         (o_state),
    .o_cycle_count   (o_cycle_count)
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    .o_stall_count   (o_stall_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_mode_step = 0; i_start = 0; i_step = 0; i_clear = 0;
    i_halt_instr = 0; i_idex_memRead = 0; i_idex_rt = 0; i_ifid_rs = 0;
    i_ifid_rt = 0; i_ifid_uses_rt = 0;
    #12;
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", o_state, ST_IDLE); end
    n_tests++; if (o_halt !== 1'b1) begin n_fail++; $display("FAIL reset_halt: got %0b expected 1", o_halt); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", o_done); end
    n_tests++; if (o_stall_pc_ifid !== 1'b0 || o_bubble_idex !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b/%0b expected 0/0", o_stall_pc_ifid, o_bubble_idex); end
    n_tests++; if (o_cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_cycle_count); end
    @(negedge clk);
    i_reset = 1'b1;
    tick();
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_idle_hold: got %0d expected %0d", o_state, ST_IDLE); end
  endtask

  task automatic test_continuous();
    i_mode_step = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_tests++; if (o_state !== ST_RUN || o_halt !== 1'b0) begin n_fail++; $display("FAIL cont_start: got state %0d halt %0b expected %0d 0", o_state, o_halt, ST_RUN); end
    repeat (9) tick();
    n_tests++; if (o_cycle_count !== 32'd9) begin n_fail++; $display("FAIL cont_count_c10: got %0d expected 9", o_cycle_count); end
    i_halt_instr = 1'b1;
    tick();
    n_tests++; if (o_state !== ST_DRAIN || o_halt !== 1'b0) begin n_fail++; $display("FAIL cont_drain_entry: got state %0d halt %0b expected %0d 0", o_state, o_halt, ST_DRAIN); end
    n_tests++; if (o_stall_pc_ifid !== 1'b1 || o_bubble_idex !== 1'b1) begin n_fail++; $display("FAIL cont_drain_stall: got %0b/%0b expected 1/1", o_stall_pc_ifid, o_bubble_idex); end
    for (int c = 12; c <= 14; c++) begin
      tick();
      n_tests++; if (o_state !== ST_DRAIN) begin n_fail++; $display("FAIL cont_drain_c%0d: got %0d expected %0d", c, o_state, ST_DRAIN); end
    end
    tick();
    n_tests++; if (o_state !== ST_DONE || o_done !== 1'b1 || o_halt !== 1'b1) begin n_fail++; $display("FAIL cont_done: got state %0d done %0b halt %0b expected %0d 1 1", o_state, o_done, o_halt, ST_DONE); end
    n_tests++; if (o_cycle_count !== 32'd14) begin n_fail++; $display("FAIL cont_count_final: got %0d expected 14", o_cycle_count); end
    i_halt_instr = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_tests++; if (o_state !== ST_DONE || o_cycle_count !== 32'd14) begin n_fail++; $display("FAIL cont_done_hold: got state %0d count %0d expected %0d 14", o_state, o_cycle_count, ST_DONE); end
    pulse_clear();
    n_tests++; if (o_state !== ST_IDLE || o_cycle_count !== 32'd0 || o_done !== 1'b0) begin n_fail++; $display("FAIL cont_clear: got state %0d count %0d done %0b expected 0 0 0", o_state, o_cycle_count, o_done); end
  endtask

  task automatic test_step();
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL step_in_idle: got %0d expected %0d", o_state, ST_IDLE); end
    i_mode_step = 1'b1; i_start = 1'b1; i_step = 1'b1;
    tick();
    i_start = 1'b0; i_step = 1'b0;
    n_tests++; if (o_state !== ST_STEP_WAIT || o_halt !== 1'b1) begin n_fail++; $display("FAIL step_start: got state %0d halt %0b expected %0d 1", o_state, o_halt, ST_STEP_WAIT); end
    for (int p = 0; p < 3; p++) begin
      repeat (4) begin
        tick();
        n_tests++; if (o_halt !== 1'b1) begin n_fail++; $display("FAIL step_wait_p%0d: got halt %0b expected 1", p, o_halt); end
      end
      i_step = 1'b1;
      tick();
      i_step = 1'b0;
      n_tests++; if (o_state !== ST_STEP_EXEC || o_halt !== 1'b0) begin n_fail++; $display("FAIL step_exec_p%0d: got state %0d halt %0b expected %0d 0", p, o_state, o_halt, ST_STEP_EXEC); end
      tick();
      n_tests++; if (o_state !== ST_STEP_WAIT || o_halt !== 1'b1) begin n_fail++; $display("FAIL step_back_p%0d: got state %0d halt %0b expected %0d 1", p, o_state, o_halt, ST_STEP_WAIT); end
    end
    n_tests++; if (o_cycle_count !== 32'd3) begin n_fail++; $display("FAIL step_count: got %0d expected 3", o_cycle_count); end
    pulse_clear();
    i_mode_step = 1'b0;
  endtask

  typedef struct {
    logic       mem_rd;
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       exp;
  } hz_vec_t;

  task automatic test_load_use();
    hz_vec_t v [6];
    v[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1};
    v[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    v[2] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0};
    v[3] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1};
    v[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0};
    v[5] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0};
    i_idex_memRead = 1'b1; i_idex_rt = 5'd5; i_ifid_rs = 5'd5;
    #1;
    n_tests++; if (o_stall_pc_ifid !== 1'b0 || o_bubble_idex !== 1'b0) begin n_fail++; $display("FAIL lu_idle_ignored: got %0b/%0b expected 0/0", o_stall_pc_ifid, o_bubble_idex); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_idex_memRead = v[k].mem_rd; i_idex_rt = v[k].idex_rt;
      i_ifid_rs = v[k].rs; i_ifid_rt = v[k].rt; i_ifid_uses_rt = v[k].uses_rt;
      #1;
      n_tests++; if (o_stall_pc_ifid !== v[k].exp || o_bubble_idex !== v[k].exp) begin n_fail++; $display("FAIL lu_vec%0d: got %0b/%0b expected %0b/%0b", k, o_stall_pc_ifid, o_bubble_idex, v[k].exp, v[k].exp); end
      n_tests++; if (o_state !== ST_RUN) begin n_fail++; $display("FAIL lu_state%0d: got %0d expected %0d", k, o_state, ST_RUN); end
      tick();
    end
    i_idex_memRead = 0; i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0; i_ifid_uses_rt = 0;
    pulse_clear();
  endtask

  task automatic test_hazard_halt();
    i_mode_step = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_idex_memRead = 1'b1; i_idex_rt = 5'd4; i_ifid_rs = 5'd4; i_halt_instr = 1'b1;
    #1;
    n_tests++; if (o_stall_pc_ifid !== 1'b1) begin n_fail++; $display("FAIL hh_stall: got %0b expected 1", o_stall_pc_ifid); end
    tick();
    n_tests++; if (o_state !== ST_RUN) begin n_fail++; $display("FAIL hh_stay_run: got %0d expected %0d", o_state, ST_RUN); end
    i_idex_memRead = 1'b0;
    tick();
    n_tests++; if (o_state !== ST_DRAIN) begin n_fail++; $display("FAIL hh_drain: got %0d expected %0d", o_state, ST_DRAIN); end
    i_halt_instr = 1'b0; i_idex_rt = 0; i_ifid_rs = 0;
    repeat (4) tick();
    n_tests++; if (o_state !== ST_DONE || o_cycle_count !== 32'd6) begin n_fail++; $display("FAIL hh_done: got state %0d count %0d expected %0d 6", o_state, o_cycle_count, ST_DONE); end
`ifdef PIPE_CTRL_STALL_CNT_EN
    n_tests++; if (o_stall_count !== 32'd1) begin n_fail++; $display("FAIL hh_stall_count: got %0d expected 1", o_stall_count); end
`endif
    pulse_clear();
  endtask

  task automatic test_clear_priority();
    i_mode_step = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_step = 1'b1;
    tick();
    i_step = 1'b0;
    tick();
    n_tests++; if (o_state !== ST_STEP_WAIT || o_cycle_count !== 32'd1) begin n_fail++; $display("FAIL clr_setup: got state %0d count %0d expected %0d 1", o_state, o_cycle_count, ST_STEP_WAIT); end
    i_clear = 1'b1; i_step = 1'b1;
    tick();
    i_clear = 1'b0; i_step = 1'b0;
    n_tests++; if (o_state !== ST_IDLE || o_cycle_count !== 32'd0 || o_halt !== 1'b1) begin n_fail++; $display("FAIL clr_priority: got state %0d count %0d halt %0b expected 0 0 1", o_state, o_cycle_count, o_halt); end
    tick();
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL clr_idle_hold: got %0d expected %0d", o_state, ST_IDLE); end
    i_mode_step = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_halt_instr = 1'b1;
    tick();
    i_halt_instr = 1'b0;
    tick();
    n_tests++; if (o_state !== ST_DRAIN) begin n_fail++; $display("FAIL rst_setup: got %0d expected %0d", o_state, ST_DRAIN); end
    #2;
    i_reset = 1'b0;
    #1;
    n_tests++; if (o_state !== ST_IDLE || o_halt !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL rst_async: got state %0d halt %0b done %0b expected 0 1 0", o_state, o_halt, o_done); end
    n_tests++; if (o_cycle_count !== 32'd0 || o_stall_pc_ifid !== 1'b0) begin n_fail++; $display("FAIL rst_counters: got count %0d stall %0b expected 0 0", o_cycle_count, o_stall_pc_ifid); end
    @(negedge clk);
    i_reset = 1'b1;
    tick();
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_release: got %0d expected %0d", o_state, ST_IDLE); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_step();
    test_load_use();
    test_hazard_halt();
    test_clear_priority();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
